// File: rtl/dm_pkg.sv
// dm_pkg: access-size encodings, controller states and index-width helper for data_mem_sync.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {DM_CLEAR, DM_RUN} dmState_t;

    function automatic int idxWidth(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dm_align.sv
// dm_align: store lane steering/byte enables and load extraction with sign/zero extension.
module dm_align
    import dm_pkg::*;
(
    input  logic [1:0]  stSize,
    input  logic [1:0]  stLane,
    input  logic [31:0] stIn,
    output logic [31:0] stData,
    output logic [3:0]  stBe,
    input  logic [31:0] ldWord,
    input  logic [1:0]  ldSize,
    input  logic [1:0]  ldLane,
    input  logic        ldUnsigned,
    output logic [31:0] ldData
);

    logic [31:0] shifted;

    always_comb begin
        stData  = stSize == SZ_BYTE ? {4{stIn[7:0]}} : stSize == SZ_HALF ? {2{stIn[15:0]}} : stIn;
        stBe    = stSize == SZ_BYTE ? 4'b0001 << stLane
                : stSize == SZ_HALF ? (stLane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        shifted = ldWord >> {ldLane, 3'b000};
        ldData  = ldSize == SZ_BYTE ? {{24{~ldUnsigned & shifted[7]}}, shifted[7:0]}
                : ldSize == SZ_HALF ? {{16{~ldUnsigned & shifted[15]}}, shifted[15:0]} : ldWord;
    end

endmodule

// File: rtl/data_mem_sync.sv
// data_mem_sync: byte/half/word data memory, registered reads, fault flagging.
// Define DM_CLEAR_EN to zero the whole array after reset before accepting requests.
module data_mem_sync
    import dm_pkg::*;
#(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [1:0]        Size,
    input  logic              Unsigned,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              ReadValid,
    output logic              AddrFault,
    output logic              Ready
);

    localparam int IDX_W = idxWidth(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [IDX_W-1:0] wordIdx, memIdx;
    logic             fault, req, doWrite, doRead, memWe;
    logic [3:0]       stBe, memBe;
    logic [31:0]      stData, memData, ldData, rdWord;
    logic [1:0]       rdSize, rdLane;
    logic             rdUns, rdPend, faultPend;

    assign wordIdx = Address[IDX_W+1:2];
    assign fault   = |(Address >> (IDX_W + 2)) || Size == 2'b11
                   || (Size == SZ_HALF && Address[0]) || (Size == SZ_WORD && |Address[1:0]);
    assign req     = Ready && (MemWrite || MemRead);
    assign doWrite = req && !fault && MemWrite;
    assign doRead  = req && !fault && MemRead && !MemWrite;

    dm_align u_align (
        .stSize    (Size),
        .stLane    (Address[1:0]),
        .stIn      (WriteData),
        .stData    (stData),
        .stBe      (stBe),
        .ldWord    (rdWord),
        .ldSize    (rdSize),
        .ldLane    (rdLane),
        .ldUnsigned(rdUns),
        .ldData    (ldData)
    );

`ifdef DM_CLEAR_EN
    dmState_t         state;
    logic [IDX_W-1:0] clrCnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= DM_CLEAR;
            clrCnt <= '0;
            Ready  <= 1'b0;
        end else if (state == DM_CLEAR) begin
            clrCnt <= clrCnt + 1'b1;
            if (&clrCnt) begin
                state <= DM_RUN;
                Ready <= 1'b1;
            end
        end
    end

    // The sweep owns the write port until it finishes; Ready=0 keeps requests out.
    assign memWe   = state == DM_CLEAR || doWrite;
    assign memIdx  = state == DM_CLEAR ? clrCnt : wordIdx;
    assign memBe   = state == DM_CLEAR ? 4'b1111 : stBe;
    assign memData = state == DM_CLEAR ? '0 : stData;
`else
    assign Ready   = 1'b1;
    assign memWe   = doWrite;
    assign memIdx  = wordIdx;
    assign memBe   = stBe;
    assign memData = stData;
`endif

    always_ff @(posedge Clk) begin
        for (int b = 0; b < 4; b++)
            if (memWe && memBe[b]) mem[memIdx][8*b +: 8] <= memData[8*b +: 8];
    end

    // Array read stage; a store at the previous edge is already visible here.
    always_ff @(posedge Clk) begin
        if (doRead) begin
            rdWord <= mem[wordIdx];
            rdSize <= Size;
            rdLane <= Address[1:0];
            rdUns  <= Unsigned;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rdPend    <= 1'b0;
            faultPend <= 1'b0;
            ReadValid <= 1'b0;
            AddrFault <= 1'b0;
            ReadData  <= '0;
        end else begin
            rdPend    <= doRead;
            faultPend <= req && fault;
            ReadValid <= rdPend;
            AddrFault <= faultPend;
            if (rdPend) ReadData <= ldData;
        end
    end

endmodule
